// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter: hands the bus over only at transfer boundaries,
// supports locked sequences and a beat quota against burst starvation.
module ahb_bus_arbiter #(
  parameter int NumMgr     = 4,
  parameter int DefaultMgr = 0,
  parameter int MaxBeats   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NumMgr-1:0]         busReq,
  input  logic [NumMgr-1:0]         lockReq,
  input  logic [1:0]                trans,
  input  logic                      ready,
  output logic [NumMgr-1:0]         grant,
  output logic [$clog2(NumMgr)-1:0] owner,
  output logic [$clog2(NumMgr)-1:0] dataOwner,
  output logic                      mastLock,
  output logic                      parked
);

  localparam int OwW = $clog2(NumMgr);
  localparam logic [1:0] TrIdle   = 2'd0;
  localparam logic [1:0] TrNonseq = 2'd2;
  localparam logic [1:0] TrSeq    = 2'd3;
  localparam logic [OwW-1:0]    DefIdx   = OwW'(DefaultMgr);
  localparam logic [NumMgr-1:0] DefGrant = {{(NumMgr-1){1'b0}}, 1'b1} << DefaultMgr;
  localparam logic [7:0]        MaxCnt   = 8'(MaxBeats);

  typedef enum logic [1:0] {
    ST_PARK  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  state_t              r_state;
  logic [NumMgr-1:0]   r_grant;
  logic [OwW-1:0]      r_owner;
  logic [OwW-1:0]      r_data_owner;
  logic [OwW-1:0]      r_rr_ptr;
  logic [7:0]          r_beat_cnt;
  logic                r_lock;
  logic                r_parked;

  logic                w_quota_hit;
  logic                w_other_req;
  logic                w_open;
  logic                w_switch;
  logic                w_found;
  logic [OwW-1:0]      w_sel;

  // Scan from ptr+1 with wrap-around so the current holder is considered last.
  function automatic logic [OwW:0] rr_pick(input logic [NumMgr-1:0] req,
                                           input logic [OwW-1:0]    ptr);
    logic [OwW:0]   res;
    logic [OwW-1:0] idx;
    res = {1'b0, DefIdx};
    for (int i = 1; i <= NumMgr; i++) begin
      idx = OwW'((int'(ptr) + i) % NumMgr);
      if (!res[OwW] && req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [NumMgr-1:0] one_hot(input logic [OwW-1:0] idx);
    logic [NumMgr-1:0] v;
    v      = {NumMgr{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Handover window and round-robin candidate for this cycle.
  always_comb begin
    w_quota_hit = (r_beat_cnt == MaxCnt);
    w_other_req = |(busReq & ~r_grant);
    w_open      = (trans == TrIdle) |
                  ((trans == TrNonseq) & (~busReq[r_owner] | (w_quota_hit & w_other_req)));
    if (r_state == ST_LOCK) begin
      w_switch = ready & (trans == TrIdle) & ~lockReq[r_owner];
    end else begin
      w_switch = ready & w_open;
    end
    {w_found, w_sel} = rr_pick(busReq, r_rr_ptr);
  end

  // Ownership FSM; a low ready freezes every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_PARK;
      r_grant      <= DefGrant;
      r_owner      <= DefIdx;
      r_data_owner <= DefIdx;
      r_rr_ptr     <= DefIdx;
      r_beat_cnt   <= 8'd0;
      r_lock       <= 1'b0;
      r_parked     <= 1'b1;
    end else if (ready) begin
      r_data_owner <= r_owner;
      if (w_switch && (w_sel != r_owner)) begin
        r_beat_cnt <= 8'd0;
      end else if (((trans == TrNonseq) || (trans == TrSeq)) && !w_quota_hit) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      if (w_switch) begin
        r_owner  <= w_sel;
        r_grant  <= one_hot(w_sel);
        r_rr_ptr <= w_sel;
        r_parked <= ~w_found;
        r_lock   <= w_found & lockReq[w_sel];
        if (!w_found) begin
          r_state <= ST_PARK;
        end else if (lockReq[w_sel]) begin
          r_state <= ST_LOCK;
        end else begin
          r_state <= ST_GRANT;
        end
      end
    end
  end

  assign grant     = r_grant;
  assign owner     = r_owner;
  assign dataOwner = r_data_owner;
  assign mastLock  = r_lock;
  assign parked    = r_parked;

endmodule

// Invariant monitor: grant is one-hot and always points at the owner.
module ahb_bus_arbiter_chk #(
  parameter int NumMgr = 4
) (
  input logic                      clk,
  input logic                      reset,
  input logic [NumMgr-1:0]         grant,
  input logic [$clog2(NumMgr)-1:0] owner
);

  grant_onehot_owner: assert property (@(posedge clk) disable iff (reset)
    ($onehot(grant) && grant[owner]));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed scoreboard bench for ahb_bus_arbiter (NumMgr=4, DefaultMgr=0, MaxBeats=8).
module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] o;
    logic [1:0] d;
    logic       m;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] busReq;
  logic [3:0] lockReq;
  logic [1:0] trans;
  logic       ready;
  logic [3:0] grant;
  logic [1:0] owner;
  logic [1:0] dataOwner;
  logic       mastLock;
  logic       parked;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(.NumMgr(4), .DefaultMgr(0), .MaxBeats(8)) dut (
    .clk(clk), .reset(reset), .busReq(busReq), .lockReq(lockReq),
    .trans(trans), .ready(ready), .grant(grant), .owner(owner),
    .dataOwner(dataOwner), .mastLock(mastLock), .parked(parked)
  );

  ahb_bus_arbiter_chk #(.NumMgr(4)) chk_i (
    .clk(clk), .reset(reset), .grant(grant), .owner(owner)
  );

  task automatic chk(input string tag, input string field,
                     input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "grant",     {4'd0, grant},     {4'd0, e.g});
      chk(tag, "owner",     {6'd0, owner},     {6'd0, e.o});
      chk(tag, "dataOwner", {6'd0, dataOwner}, {6'd0, e.d});
      chk(tag, "mastLock",  {7'd0, mastLock},  {7'd0, e.m});
      chk(tag, "parked",    {7'd0, parked},    {7'd0, e.p});
    end
  endtask

  task automatic step(input string tag, input logic [3:0] b, input logic [3:0] l,
                      input logic [1:0] t, input logic r,
                      input logic [3:0] eg, input logic [1:0] eo, input logic [1:0] ed,
                      input logic em, input logic ep);
    busReq  = b;
    lockReq = l;
    trans   = t;
    ready   = r;
    sb.push_back({eg, eo, ed, em, ep});
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    reset = 1'b1; busReq = 4'b0000; lockReq = 4'b0000; trans = IDLE; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back({4'b0001, 2'd0, 2'd0, 1'b0, 1'b1});
    pop_check("reset_hold");
    reset = 1'b0;

    step("park_idle", 4'b0000, 4'b0000, IDLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, 1'b1);

    // Round robin: each owner drops its request together with its single NONSEQ.
    step("rr_e1", 4'b1110, 4'b0000, IDLE,   1'b1, 4'b0010, 2'd1, 2'd0, 1'b0, 1'b0);
    step("rr_e2", 4'b1100, 4'b0000, NONSEQ, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0, 1'b0);
    step("rr_e3", 4'b1010, 4'b0000, NONSEQ, 1'b1, 4'b1000, 2'd3, 2'd2, 1'b0, 1'b0);
    step("rr_e4", 4'b0110, 4'b0000, NONSEQ, 1'b1, 4'b0010, 2'd1, 2'd3, 1'b0, 1'b0);
    step("rr_e5", 4'b0100, 4'b0000, NONSEQ, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      step($sformatf("stall_%0d", i), 4'b1100, 4'b0000, NONSEQ, 1'b0,
           4'b0100, 2'd2, 2'd1, 1'b0, 1'b0);
    end
    step("stall_done", 4'b1100, 4'b0000, NONSEQ, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, 1'b0);
    step("idle_to3",   4'b1100, 4'b0000, IDLE,   1'b1, 4'b1000, 2'd3, 2'd2, 1'b0, 1'b0);
    step("idle_to1",   4'b0010, 4'b0000, IDLE,   1'b1, 4'b0010, 2'd1, 2'd3, 1'b0, 1'b0);

    // Quota: 7 beats, NONSEQ as beat 8 (no cut), SEQ at saturation, then cut at NONSEQ.
    step("quota_b1", 4'b0110, 4'b0000, NONSEQ, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0, 1'b0);
    for (int i = 2; i <= 7; i++) begin
      step($sformatf("quota_b%0d", i), 4'b0110, 4'b0000, SEQ, 1'b1,
           4'b0010, 2'd1, 2'd1, 1'b0, 1'b0);
    end
    step("quota_b8_ns", 4'b0110, 4'b0000, NONSEQ, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0, 1'b0);
    step("quota_sat",   4'b0110, 4'b0000, SEQ,    1'b1, 4'b0010, 2'd1, 2'd1, 1'b0, 1'b0);
    step("quota_cut",   4'b0110, 4'b0000, NONSEQ, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0, 1'b0);
    step("quota_clr",   4'b0110, 4'b0000, NONSEQ, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, 1'b0);

    // Burst protection, then handover into a locked sequence for mgr3.
    step("burst_busy", 4'b1011, 4'b1000, BUSY,   1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, 1'b0);
    step("burst_seq",  4'b1011, 4'b1000, SEQ,    1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, 1'b0);
    step("lock_enter", 4'b1011, 4'b1000, NONSEQ, 1'b1, 4'b1000, 2'd3, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step($sformatf("lock_x%0d", i), 4'b1011, 4'b1010, (i % 4 == 0) ? NONSEQ : SEQ,
           1'b1, 4'b1000, 2'd3, 2'd3, 1'b1, 1'b0);
    end
    step("lock_idle_held", 4'b1011, 4'b1010, IDLE, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1, 1'b0);
    step("lock_exit",      4'b1011, 4'b0010, IDLE, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0, 1'b0);

    step("repark",   4'b0000, 4'b0000, IDLE,   1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, 1'b1);
    step("to2",      4'b0100, 4'b0000, IDLE,   1'b1, 4'b0100, 2'd2, 2'd0, 1'b0, 1'b0);
    step("own2_ns",  4'b0100, 4'b0000, NONSEQ, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset = 1'b1;
    #1;
    sb.push_back({4'b0001, 2'd0, 2'd0, 1'b0, 1'b1});
    pop_check("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // All managers request at once after reset.
    step("all_e1", 4'b1111, 4'b0000, IDLE, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0, 1'b0);
    step("all_e2", 4'b1111, 4'b0000, IDLE, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0, 1'b0);
    step("all_e3", 4'b1111, 4'b0000, IDLE, 1'b1, 4'b1000, 2'd3, 2'd2, 1'b0, 1'b0);
    step("all_e4", 4'b1111, 4'b0000, IDLE, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
